// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX -> MEM pipeline register with a 2-entry skid buffer.
//   Accepts EX results from the ID/EX handshake and presents them, with the
//   passthrough MEM/WB control fields, to the MEM stage.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
//   valid and ready are both high in the cycle before that edge. A producer
//   that raises valid keeps valid and its payload stable until the transfer.
//   ex_ready never depends combinationally on mem_ready. It decodes only the
//   state register, so the ready chain is cut at this stage.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   flush                 drop every held entry (redirect / exception)
//   id_valid / ex_ready   upstream handshake
//   EX_*                  incoming payload
//   ex_valid / mem_ready  downstream handshake
//   MEM_*                 registered payload, driven from the main entry
//   dbg_state             FSM state (0 EMPTY, 1 BUSY, 2 FULL)

module ex_mem_stage #(
   parameter int DATA_W = 64,
   parameter int PC_W   = 64,
   parameter int REG_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              id_valid,
   output logic              ex_ready,
   input  logic [PC_W-1:0]   EX_pc,
   input  logic              EX_w_ena,
   input  logic [REG_W-1:0]  EX_w_addr,
   input  logic [DATA_W-1:0] EX_alu_res,
   input  logic [DATA_W-1:0] EX_data2,
   input  logic [2:0]        EX_memwop,
   input  logic [2:0]        EX_memrop,
   input  logic              EX_mem_ena,
   input  logic              EX_mem_wr,
   input  logic              mem_ready,
   output logic              ex_valid,
   output logic [PC_W-1:0]   MEM_pc,
   output logic              MEM_w_ena,
   output logic [REG_W-1:0]  MEM_w_addr,
   output logic [DATA_W-1:0] MEM_alu_res,
   output logic [DATA_W-1:0] MEM_data2,
   output logic [2:0]        MEM_memwop,
   output logic [2:0]        MEM_memrop,
   output logic              MEM_mem_ena,
   output logic              MEM_mem_wr,
   output logic [1:0]        dbg_state
);

   localparam int PW = PC_W + 1 + REG_W + 2 * DATA_W + 3 + 3 + 1 + 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t          state;
   logic [PW-1:0]   in_pl;
   logic [PW-1:0]   main_q;
   logic [PW-1:0]   skid_q;
   logic            in_fire;
   logic            out_fire;

   // All payload fields travel as one flat vector; no field is modified.
   assign in_pl = {EX_pc, EX_w_ena, EX_w_addr, EX_alu_res, EX_data2,
                   EX_memwop, EX_memrop, EX_mem_ena, EX_mem_wr};

   assign {MEM_pc, MEM_w_ena, MEM_w_addr, MEM_alu_res, MEM_data2,
           MEM_memwop, MEM_memrop, MEM_mem_ena, MEM_mem_wr} = main_q;

   // Flush hides the head entry in the same cycle and blocks both transfers.
   assign ex_valid  = (state != EMPTY) & ~flush;
   assign ex_ready  = (state != FULL);
   assign in_fire   = id_valid & ex_ready & ~flush;
   assign out_fire  = ex_valid & mem_ready;
   assign dbg_state = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         // Payload registers keep their contents; only occupancy is cleared.
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_q <= in_pl;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_q <= in_pl;
               end else if (in_fire) begin
                  // MEM is stalled: park the new entry behind the head.
                  skid_q <= in_pl;
                  state  <= FULL;
               end else if (out_fire) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               // ex_ready is low here, so only the drain side can fire.
               if (out_fire) begin
                  main_q <= skid_q;
                  state  <= BUSY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule
